// File: rtl/ball_pkg.sv
// Shared types and constants for the per-frame ball motion scheduler.
package ball_pkg;

  localparam int unsigned POS_W_DEFAULT = 9;
  localparam int unsigned BALL_H_INIT   = 128;
  localparam int unsigned BALL_V_INIT   = 128;
  localparam int unsigned BALL_VEL_INIT = 2;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    MOVE,
    COMMIT,
    DONE
  } state_e;

  typedef struct packed {
    logic [POS_W_DEFAULT-1:0] hpos;
    logic [POS_W_DEFAULT-1:0] vpos;
    logic [POS_W_DEFAULT-1:0] dx;
    logic [POS_W_DEFAULT-1:0] dy;
  } ball_entry_t;

endpackage

// File: rtl/ball_frame_scheduler_if.sv
// Frame-control, config-write and renderer-read signals of the ball scheduler.
interface ball_frame_scheduler_if #(
  parameter int unsigned NUM_BALLS = 4,
  parameter int unsigned POS_W     = 9
);
  localparam int unsigned IDX_W = $clog2(NUM_BALLS);

  logic                 vsync;
  logic                 enable;
  logic                 cfg_we;
  logic [IDX_W-1:0]     cfg_idx;
  logic [POS_W-1:0]     cfg_hpos;
  logic [POS_W-1:0]     cfg_vpos;
  logic [POS_W-1:0]     cfg_dx;
  logic [POS_W-1:0]     cfg_dy;
  logic                 cfg_ready;
  logic [IDX_W-1:0]     rd_idx;
  logic [POS_W-1:0]     rd_hpos;
  logic [POS_W-1:0]     rd_vpos;
  logic                 busy;
  logic                 frame_done;
  logic [NUM_BALLS-1:0] hit_mask;
  logic                 overrun;

  modport master (
    output vsync, enable, cfg_we, cfg_idx, cfg_hpos, cfg_vpos, cfg_dx, cfg_dy, rd_idx,
    input  cfg_ready, rd_hpos, rd_vpos, busy, frame_done, hit_mask, overrun
  );

  modport slave (
    input  vsync, enable, cfg_we, cfg_idx, cfg_hpos, cfg_vpos, cfg_dx, cfg_dy, rd_idx,
    output cfg_ready, rd_hpos, rd_vpos, busy, frame_done, hit_mask, overrun
  );
endinterface

// File: rtl/ball_step.sv
// Single-axis step with reflection at 0 and lim; shared by the h and v lanes.
module ball_step #(
  parameter int unsigned POS_W = 9
) (
  input  logic [POS_W-1:0] pos_i,
  input  logic [POS_W-1:0] vel_i,
  input  logic [POS_W-1:0] lim_i,
  output logic [POS_W-1:0] pos_o,
  output logic [POS_W-1:0] vel_o,
  output logic             bounce_o
);
  logic signed [POS_W:0] nxt;
  logic signed [POS_W:0] lim_s;
  logic                  vel_pos;
  logic                  vel_neg;

  // One extra bit so pos + vel cannot wrap before the limit tests.
  always_comb begin
    lim_s   = $signed({1'b0, lim_i});
    nxt     = $signed({1'b0, pos_i}) + $signed({vel_i[POS_W-1], vel_i});
    vel_neg = vel_i[POS_W-1];
    vel_pos = !vel_neg && (|vel_i);
    pos_o    = nxt[POS_W-1:0];
    vel_o    = vel_i;
    bounce_o = 1'b0;
    if (vel_pos && (nxt >= lim_s)) begin
      pos_o    = lim_i;
      vel_o    = -vel_i;
      bounce_o = 1'b1;
    end else if (vel_neg && nxt[POS_W]) begin
      pos_o    = '0;
      vel_o    = -vel_i;
      bounce_o = 1'b1;
    end
  end
endmodule

// File: rtl/ball_frame_scheduler.sv
// Time-multiplexes one h/v step datapath over all balls after each vsync edge
// and holds the position/velocity file read by the renderer.
module ball_frame_scheduler
  import ball_pkg::*;
#(
  parameter int unsigned NUM_BALLS = 4,
  parameter int unsigned POS_W     = POS_W_DEFAULT,
  parameter int unsigned BALL_SIZE = 4,
  parameter int unsigned H_MAX     = 256,
  parameter int unsigned V_MAX     = 240
) (
  input  logic                   clk,
  input  logic                   reset,
  ball_frame_scheduler_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(NUM_BALLS);
  localparam logic [POS_W-1:0] H_LIM = POS_W'(H_MAX - BALL_SIZE);
  localparam logic [POS_W-1:0] V_LIM = POS_W'(V_MAX - BALL_SIZE);
  localparam ball_entry_t ENTRY_INIT = '{
    hpos: POS_W'(BALL_H_INIT),
    vpos: POS_W'(BALL_V_INIT),
    dx:   POS_W'(BALL_VEL_INIT),
    dy:   POS_W'(BALL_VEL_INIT)
  };

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  ball_entry_t          work_q, work_d;
  logic                 bounce_q, bounce_d;
  logic [NUM_BALLS-1:0] hit_q, hit_d;
  logic                 vsync_q;
  logic                 busy_q, done_q, overrun_q;
  ball_entry_t          regfile_q [NUM_BALLS];

  logic                 vs_edge;
  logic                 wr_en;
  logic [IDX_W-1:0]     wr_idx;
  ball_entry_t          wr_data;
  logic [POS_W-1:0]     h_nxt, v_nxt, dx_nxt, dy_nxt;
  logic                 h_bounce, v_bounce;

  assign vs_edge = bus.vsync & ~vsync_q;

  ball_step #(.POS_W(POS_W)) u_step_h (
    .pos_i(work_q.hpos), .vel_i(work_q.dx), .lim_i(H_LIM),
    .pos_o(h_nxt), .vel_o(dx_nxt), .bounce_o(h_bounce)
  );

  ball_step #(.POS_W(POS_W)) u_step_v (
    .pos_i(work_q.vpos), .vel_i(work_q.dy), .lim_i(V_LIM),
    .pos_o(v_nxt), .vel_o(dy_nxt), .bounce_o(v_bounce)
  );

  // Sequencer; the register file has a single write port shared by config and commit.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    work_d   = work_q;
    bounce_d = bounce_q;
    hit_d    = hit_q;
    wr_en    = 1'b0;
    wr_idx   = idx_q;
    wr_data  = work_q;
    case (state_q)
      IDLE: begin
        if (bus.cfg_we) begin
          wr_en   = 1'b1;
          wr_idx  = bus.cfg_idx;
          wr_data = '{hpos: bus.cfg_hpos, vpos: bus.cfg_vpos, dx: bus.cfg_dx, dy: bus.cfg_dy};
        end
        if (vs_edge && bus.enable) begin
          idx_d   = '0;
          hit_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        work_d  = regfile_q[idx_q];
        state_d = MOVE;
      end
      MOVE: begin
        work_d   = '{hpos: h_nxt, vpos: v_nxt, dx: dx_nxt, dy: dy_nxt};
        bounce_d = h_bounce | v_bounce;
        state_d  = COMMIT;
      end
      COMMIT: begin
        wr_en         = 1'b1;
        hit_d[idx_q]  = hit_q[idx_q] | bounce_q;
        if (idx_q == IDX_W'(NUM_BALLS - 1)) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = FETCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      work_q    <= '0;
      bounce_q  <= 1'b0;
      hit_q     <= '0;
      vsync_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      work_q    <= work_d;
      bounce_q  <= bounce_d;
      hit_q     <= hit_d;
      vsync_q   <= bus.vsync;
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
      overrun_q <= vs_edge && (state_q != IDLE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < int'(NUM_BALLS); k++) regfile_q[k] <= ENTRY_INIT;
    end else if (wr_en) begin
      regfile_q[wr_idx] <= wr_data;
    end
  end

  // Renderer read; indices past the last ball return zero.
  always_comb begin
    bus.rd_hpos = '0;
    bus.rd_vpos = '0;
    for (int k = 0; k < int'(NUM_BALLS); k++) begin
      if (bus.rd_idx == IDX_W'(k)) begin
        bus.rd_hpos = regfile_q[k].hpos;
        bus.rd_vpos = regfile_q[k].vpos;
      end
    end
  end

  assign bus.cfg_ready  = (state_q == IDLE);
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign bus.hit_mask   = hit_q;
  assign bus.overrun    = overrun_q;
endmodule
